// File: rtl/puf_response_tx_scheduler_if.sv
// Bus bundle between the PUF response TX scheduler and its environment
// (session control, response FIFO read side, UART transmit handshake).
interface puf_response_tx_scheduler_if #(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MAX_WORDS = 1280
);
    localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);

    // session control
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [WC_W-1:0]      word_count;
    // response FIFO read side
    logic                 fifo_empty;
    logic [WORD_BITS-1:0] fifo_dout;
    logic                 fifo_re;
    // UART transmit handshake
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_enable;
    logic                 tx_busy;

    // scheduler side
    modport master (
        input  start, fifo_empty, fifo_dout, tx_busy,
        output busy, done, word_count, fifo_re, tx_data, tx_enable
    );

    // environment side (main FSM, FIFO, UART)
    modport slave (
        output start, fifo_empty, fifo_dout, tx_busy,
        input  busy, done, word_count, fifo_re, tx_data, tx_enable
    );
endinterface

// File: rtl/puf_response_tx_scheduler.sv
// PUF response TX scheduler: sends a header byte, then drains the response
// FIFO word by word, serialising each word MSB-first into UART bytes, and
// pulses done when the FIFO is empty or MAX_WORDS words have been sent.
// Optional trailing XOR checksum byte: define PUF_TX_CHECKSUM_EN.
module puf_response_tx_scheduler #(
    parameter int unsigned          WORD_BITS   = 32,
    parameter int unsigned          DATA_BITS   = 8,
    parameter int unsigned          MAX_WORDS   = 1280,
    parameter logic [DATA_BITS-1:0] RESPONSE_ID = 8'b10101010
) (
    input logic                         clk,
    input logic                         reset,
    puf_response_tx_scheduler_if.master bus
);
    localparam int unsigned BYTES = WORD_BITS / DATA_BITS;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned WC_W  = $clog2(MAX_WORDS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_LATCH,
        S_LOAD,
        S_TX_REQ,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_FINISH,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               ret_q;
    logic [WORD_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WC_W-1:0]      wc_q;
    logic [DATA_BITS-1:0] tx_data_q;
    logic                 tx_enable_q;
    logic                 fifo_re_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef PUF_TX_CHECKSUM_EN
    logic [DATA_BITS-1:0] csum_q;
`endif

    // Another word may be popped: FIFO holds data and the session cap is not hit.
    // Only this block pops the FIFO, so a non-empty flag seen here cannot turn
    // empty before the following CHECK cycle.
    logic pop_ok;
    assign pop_ok = !bus.fifo_empty && (wc_q != WC_MAX);

    // Session sequencer; every output is a flop updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            wc_q        <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            fifo_re_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PUF_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            tx_enable_q <= 1'b0;
            fifo_re_q   <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        tx_data_q <= RESPONSE_ID;
                        wc_q      <= '0;
                        busy_q    <= 1'b1;
                        ret_q     <= S_CHECK;
                        state_q   <= S_TX_REQ;
`ifdef PUF_TX_CHECKSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                // fifo_re was raised on entry to this state, so it is high for
                // exactly this cycle and the word is readable in LATCH.
                S_CHECK: begin
                    state_q <= fifo_re_q ? S_LATCH : S_FINISH;
                end
                S_LATCH: begin
                    shift_q <= bus.fifo_dout;
                    idx_q   <= '0;
                    if (wc_q != WC_MAX) begin
                        wc_q <= wc_q + WC_W'(1);
                    end
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    tx_data_q <= shift_q[WORD_BITS-1 -: DATA_BITS];
`ifdef PUF_TX_CHECKSUM_EN
                    csum_q    <= csum_q ^ shift_q[WORD_BITS-1 -: DATA_BITS];
`endif
                    ret_q     <= (idx_q == LAST_IDX) ? S_CHECK : S_LOAD;
                    state_q   <= S_TX_REQ;
                end
                S_TX_REQ: begin
                    if (!bus.tx_busy) begin
                        tx_enable_q <= 1'b1;
                        state_q     <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state_q <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!bus.tx_busy) begin
                        state_q <= ret_q;
                        if (ret_q == S_LOAD) begin
                            shift_q <= shift_q << DATA_BITS;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                        if (ret_q == S_CHECK) begin
                            fifo_re_q <= pop_ok;
                        end
                    end
                end
`ifdef PUF_TX_CHECKSUM_EN
                S_FINISH: begin
                    tx_data_q <= csum_q;
                    ret_q     <= S_DONE;
                    state_q   <= S_TX_REQ;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
`else
                S_FINISH, S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.word_count = wc_q;
    assign bus.fifo_re    = fifo_re_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_enable  = tx_enable_q;

endmodule

// File: tb/tb_puf_response_tx_scheduler.sv
// Scoreboard bench for puf_response_tx_scheduler: a FIFO model, a UART model
// and a byte monitor run alongside directed and randomised sessions.
module tb_puf_response_tx_scheduler;
    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MAX_WORDS = 2;
    localparam int unsigned BYTES     = WORD_BITS / DATA_BITS;
    localparam int          BUDGET    = 3000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    puf_response_tx_scheduler_if #(
        .WORD_BITS(WORD_BITS), .DATA_BITS(DATA_BITS), .MAX_WORDS(MAX_WORDS)
    ) bus ();

    puf_response_tx_scheduler #(
        .WORD_BITS(WORD_BITS), .DATA_BITS(DATA_BITS),
        .MAX_WORDS(MAX_WORDS), .RESPONSE_ID(8'hAA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [WORD_BITS-1:0] fifo_q[$];
    logic [DATA_BITS-1:0] exp_q[$];
    int   n_pop    = 0;
    int   n_done   = 0;
    int   n_tx     = 0;
    int   busy_cnt = 0;
    int   busy_len = 0;
    logic ext_hold = 1'b0;
    bit   in_flight = 1'b0;
    logic [DATA_BITS-1:0] last_byte = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    initial begin
        bus.start      = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        bus.tx_busy    = 1'b0;
    end

    // FIFO model: pops on fifo_re, data readable from the following cycle
    always @(negedge clk) begin
        if (bus.fifo_re === 1'b1) begin
            n_pop++;
            check("fifo_re_while_empty", 64'(fifo_q.size() == 0), 64'd0);
            if (fifo_q.size() != 0) bus.fifo_dout = fifo_q.pop_front();
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    end

    // UART model plus scoreboard monitor for transmitted bytes
    always @(negedge clk) begin
        if (reset) in_flight = 1'b0;
        if (bus.tx_enable === 1'b1) begin
            check("tx_enable_while_busy", 64'(bus.tx_busy), 64'd0);
            n_tx++;
            last_byte = bus.tx_data;
            in_flight = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got=%0h expected=none (t=%0t)", bus.tx_data, $time);
            end else begin
                check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
            end
            busy_cnt = (busy_len > 0) ? busy_len : int'($urandom_range(6, 1));
        end else if (busy_cnt > 0) begin
            if (in_flight) check("tx_data_stable", 64'(bus.tx_data), 64'(last_byte));
            busy_cnt--;
            if (busy_cnt == 0) in_flight = 1'b0;
        end
        bus.tx_busy = (busy_cnt > 0) || ext_hold;
    end

    // done monitor
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_done++;
            check("busy_low_at_done", 64'(bus.busy), 64'd0);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_fifo_re"},    64'(bus.fifo_re),    64'd0);
        check({tag, "_tx_enable"},  64'(bus.tx_enable),  64'd0);
        check({tag, "_busy"},       64'(bus.busy),       64'd0);
        check({tag, "_done"},       64'(bus.done),       64'd0);
        check({tag, "_tx_data"},    64'(bus.tx_data),    64'd0);
        check({tag, "_word_count"}, 64'(bus.word_count), 64'd0);
    endtask

    task automatic wait_uart_idle();
        int cyc = 0;
        while ((bus.tx_busy !== 1'b0) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("uart_idle_timeout", 64'(bus.tx_busy), 64'd0);
    endtask

    // Expected bytes come from the queued FIFO contents at session start.
    task automatic push_expected(output int n_take);
        logic [WORD_BITS-1:0] w;
        logic [DATA_BITS-1:0] b;
        logic [DATA_BITS-1:0] cs;
        n_take = (fifo_q.size() < MAX_WORDS) ? fifo_q.size() : MAX_WORDS;
        cs = '0;
        exp_q.push_back(8'hAA);
        for (int i = 0; i < n_take; i++) begin
            w = fifo_q[i];
            for (int k = 0; k < BYTES; k++) begin
                b = w[WORD_BITS-1-k*DATA_BITS -: DATA_BITS];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
`ifdef PUF_TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic run_session(input bit lat_chk, input bit extra_start, input int pre_hold);
        int n_take, left, pop0, done0, tx0, cyc;
        push_expected(n_take);
        left  = fifo_q.size() - n_take;
        pop0  = n_pop;
        done0 = n_done;
        tx0   = n_tx;
        if (pre_hold > 0) begin
            ext_hold = 1'b1;
            @(negedge clk);
        end
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        if (lat_chk) begin
            @(negedge clk);
            check("start_to_tx_enable", 64'(bus.tx_enable), 64'd1);
        end
        if (pre_hold > 0) begin
            repeat (pre_hold) @(negedge clk);
            check("no_tx_during_hold", 64'(n_tx - tx0), 64'd0);
            ext_hold = 1'b0;
        end
        if (extra_start && n_take > 0) begin
            cyc = 0;
            while ((n_tx - tx0) < 2 && cyc < BUDGET) begin
                @(negedge clk);
                cyc++;
            end
            bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
            check("busy_after_ignored_start", 64'(bus.busy), 64'd1);
        end
        cyc = 0;
        while (n_done == done0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("session_done", 64'(n_done - done0), 64'd1);
        repeat (3) @(negedge clk);
        check("done_single_pulse", 64'(n_done - done0), 64'd1);
        check("word_count",        64'(bus.word_count), 64'(n_take));
        check("fifo_pops",         64'(n_pop - pop0),   64'(n_take));
        check("fifo_left",         64'(fifo_q.size()),  64'(left));
        check("all_bytes_sent",    64'(exp_q.size()),   64'd0);
        check("busy_after_done",   64'(bus.busy),       64'd0);
    endtask

    task automatic load_words(input logic [WORD_BITS-1:0] w);
        fifo_q.push_back(w);
    endtask

    initial begin
        int pop0, tx0, cyc, n_take, nw;

        // power-on reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_values("por");

        // single word, 10-cycle UART, latency checked
        busy_len = 10;
        load_words(32'hDEADBEEF);
        repeat (2) @(negedge clk);
        run_session(1'b1, 1'b0, 0);

        // empty FIFO: header only
        run_session(1'b0, 1'b0, 0);

        // session cap: three words queued, two sent
        load_words(32'h01020304);
        load_words(32'h05060708);
        load_words(32'h090A0B0C);
        repeat (2) @(negedge clk);
        run_session(1'b0, 1'b0, 0);
        check("fifo_not_empty_after_cap", 64'(bus.fifo_empty), 64'd0);
        run_session(1'b0, 1'b0, 0);

        // UART held busy before header, extra start during word 1
        load_words(32'hCAFEF00D);
        load_words(32'h12345678);
        repeat (2) @(negedge clk);
        run_session(1'b0, 1'b1, 50);

        // start and reset together: reset wins
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check_reset_values("rst_start");
        @(negedge clk);
        check("rst_start_no_session", 64'(bus.busy), 64'd0);

        // reset in WAIT_IDLE of a payload byte, then a fresh session
        load_words(32'hA1B2C3D4);
        load_words(32'h0F1E2D3C);
        load_words(32'h55667788);
        repeat (2) @(negedge clk);
        pop0 = n_pop;
        tx0  = n_tx;
        push_expected(n_take);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        cyc = 0;
        while ((n_tx - tx0) < 3 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_byte2", 64'(n_tx - tx0), 64'd3);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("mid_rst");
        check("mid_rst_pops",       64'(n_pop - pop0),  64'd1);
        check("mid_rst_fifo_intact", 64'(fifo_q.size()), 64'd2);
        wait_uart_idle();
        run_session(1'b0, 1'b0, 0);

        // randomised sessions
        busy_len = 0;
        for (int s = 0; s < 10; s++) begin
            nw = int'($urandom_range(3, 0));
            for (int i = 0; i < nw; i++) load_words($urandom);
            repeat (2) @(negedge clk);
            run_session(1'b0, 1'($urandom_range(1, 0)), 0);
            // drain any words left behind by the session cap
            while (fifo_q.size() != 0) run_session(1'b0, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/puf_response_tx_scheduler.md
Name: puf_response_tx_scheduler

Overview:
- Sequences the return path from the PUF response FIFO to the UART transmitter.
- On a start pulse from the main state machine, it sends one header byte (RESPONSE_ID).
- It then pops 32-bit response words from the FIFO one at a time and serialises each into bytes, MSB first, over the UART TX handshake.
- It pulses done when the FIFO drains or when MAX_WORDS words have been sent.

Parameters:
- WORD_BITS, 32: FIFO word width; must be an integer multiple of DATA_BITS.
- DATA_BITS, 8: UART byte width.
- MAX_WORDS, 1280: maximum words per session; sized to NUM_LOOPS.
- RESPONSE_ID, 8'b10101010: header byte sent first in every session.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle session request; ignored unless busy=0
- fifo_empty  in  1  response FIFO empty flag
- fifo_dout  in  WORD_BITS  FIFO read data; valid one cycle after fifo_re
- fifo_re  out  1  FIFO read strobe, single cycle
- tx_data  out  DATA_BITS  byte to UART
- tx_enable  out  1  single-cycle send request to UART
- tx_busy  in  1  UART transmitter busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at end of session
- word_count  out  $clog2(MAX_WORDS+1)  words sent in the current/last session

Behaviour:
- Reset (sync, reset=1 at a clk edge):
  - state=IDLE.
  - fifo_re, tx_enable, busy, done = 0; tx_data=0; word_count=0; byte index=0.
  - FIFO contents are not touched. The same applies to reset mid-session, including mid-byte: tx_enable drops to 0 in the next cycle and no further pops occur.
- BYTES = WORD_BITS/DATA_BITS (4 by default). Byte k of a word is word[WORD_BITS-1-k*DATA_BITS -: DATA_BITS], k = 0..BYTES-1.
- States:
  - IDLE:
    - start=1 → load tx_data=RESPONSE_ID, clear word_count and checksum, busy=1, go to TX_REQ with return state CHECK.
  - CHECK:
    - if fifo_empty=1 or word_count==MAX_WORDS → FINISH.
    - otherwise assert fifo_re=1 for exactly this cycle → LATCH.
  - LATCH:
    - capture fifo_dout into a shift register, byte index=0, word_count+=1 (saturates at MAX_WORDS).
    - go to LOAD.
  - LOAD:
    - tx_data = current byte → TX_REQ.
    - return state is LOAD if byte index < BYTES-1 (index incremented on return), else CHECK.
  - TX_REQ:
    - wait while tx_busy=1.
    - when tx_busy=0, assert tx_enable=1 for one cycle → WAIT_ACK.
  - WAIT_ACK:
    - wait until tx_busy=1 → WAIT_IDLE.
  - WAIT_IDLE:
    - wait until tx_busy=0 → return state.
  - FINISH:
    - with checksum enabled, see Optional Feature.
    - otherwise done=1 for one cycle, busy=0 → IDLE.
- tx_data is stable from the tx_enable cycle until WAIT_IDLE exits.
- Never more than one byte is in flight. fifo_re is never asserted while fifo_empty=1.
- Latency, start to first tx_enable, with tx_busy=0: 2 cycles.
- Per word: CHECK→LATCH→LOAD adds 3 cycles of overhead before the first byte's TX_REQ.
- Boundary rules:
  - start while busy: ignored.
  - start and reset in the same cycle: reset wins.
  - Empty FIFO at start: header only; word_count=0; done pulses.
  - fifo_empty rising mid-word: no effect; the latched word is fully sent.
  - New FIFO writes during a session are sent if present at the next CHECK.
  - word_count==MAX_WORDS: session ends even if the FIFO is non-empty; remaining words stay queued.
- Wrap: byte index wraps 0..BYTES-1; word_count does not wrap.

Optional Feature:
- Macro: PUF_TX_CHECKSUM_EN.
- Defined:
  - an 8-bit running XOR of all payload bytes is accumulated; the header is excluded.
  - In FINISH: tx_data=checksum → TX_REQ, return to a terminal state that pulses done.
  - Empty session checksum = 8'h00.
- Undefined: no checksum byte; FINISH pulses done directly. Ports are unchanged.

Test Plan:
- Reset, then start with FIFO holding 32'hDEADBEEF; UART model holds tx_busy for 10 cycles per byte → TX bytes AA, DE, AD, BE, EF; one fifo_re; word_count=1; one done pulse. With the checksum macro, a sixth byte 8'h22.
- Start with FIFO empty → only byte AA sent; fifo_re never high; done; word_count=0. With the checksum macro, AA then 00.
- MAX_WORDS=2 with FIFO holding 3 words 32'h01020304, 32'h05060708, 32'h090A0B0C → 9 bytes sent (AA, 01..08); word_count=2; fifo_empty still 0 afterwards.
- Second start pulse during word 1, plus tx_busy held high 50 cycles before the header → start ignored; tx_enable waits until tx_busy=0; byte order unchanged.
- reset asserted during WAIT_IDLE of byte 2 → next cycle all outputs at reset values; remaining FIFO words intact; a new start re-sends the header AA.
